rr_arbiter_fsm: RTL and testbench

//  Parametrised N-agent bus arbiter; next generation of the 4-agent fixed-priority grant FSM.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_arbiter_fsm.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority encoder: first set request at or above the
// start index, scanning a doubled request vector so the search wraps.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               rr_mode,
    output logic [IDW-1:0]     winner_c,
    output logic               any_c
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [IDW-1:0]       base;
    logic                 found;

    always_comb begin
        dbl      = {req, req};
        base     = (rr_mode == MODE_RR) ? ptr : '0;
        found    = 1'b0;
        winner_c = '0;
        any_c    = |req;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && (i >= int'(base)) && dbl[i]) begin
                found    = 1'b1;
                winner_c = IDW'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// N-agent bus arbiter with runtime round-robin / fixed priority, bounded
// grant tenure with preemption, and registered one-hot grant outputs.
module rr_arbiter_fsm
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IDW     = $clog2(NUM_REQ),
    localparam int unsigned CW      = clog2_min1(MAX_HOLD + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDW-1:0]     gnt_id,
    output logic               preempt,
    output logic [CW-1:0]      busy_cnt
);

    localparam logic          UNLIMITED = (MAX_HOLD == 0);
    localparam logic [CW-1:0] HOLD_LIM  = UNLIMITED ? '1 : CW'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               preempt_q, preempt_d;
    logic [CW-1:0]      busy_cnt_q, busy_cnt_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [IDW-1:0]     pick_winner_c;
    logic               pick_any_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req      (req),
        .ptr      (rr_ptr_q),
        .rr_mode  (rr_mode),
        .winner_c (pick_winner_c),
        .any_c    (pick_any_c)
    );

    // Next-state and output logic; every tenure exit lands in IDLE so a dead cycle follows.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = 1'b0;
        busy_cnt_d  = busy_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                busy_cnt_d  = '0;
                if (pick_any_c) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << pick_winner_c;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_winner_c;
                    busy_cnt_d  = CW'(1);
                    rr_ptr_d    = (pick_winner_c == IDW'(NUM_REQ - 1)) ? '0
                                                                       : pick_winner_c + IDW'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    busy_cnt_d  = '0;
                end else if (UNLIMITED || (busy_cnt_q < HOLD_LIM)) begin
                    if (busy_cnt_q != '1) begin
                        busy_cnt_d = busy_cnt_q + CW'(1);
                    end
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    busy_cnt_d  = '0;
                    preempt_d   = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                busy_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            busy_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            busy_cnt_q  <= busy_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed and randomised self-checking bench for rr_arbiter_fsm.
module tb_rr_arbiter_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic       rr_mode = 1'b0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       preempt;
    logic [2:0] busy_cnt;

    logic [3:0] req_inf = '0;
    logic [3:0] gnt_inf;
    logic       gnt_valid_inf;
    logic [1:0] gnt_id_inf;
    logic       preempt_inf;
    logic [0:0] busy_cnt_inf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    rr_arbiter_fsm #(.NUM_REQ(4), .MAX_HOLD(4)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt),
        .busy_cnt  (busy_cnt)
    );

    rr_arbiter_fsm #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut_inf (
        .clock     (clock),
        .reset     (reset),
        .req       (req_inf),
        .rr_mode   (1'b0),
        .gnt       (gnt_inf),
        .gnt_valid (gnt_valid_inf),
        .gnt_id    (gnt_id_inf),
        .preempt   (preempt_inf),
        .busy_cnt  (busy_cnt_inf)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                               input logic [2:0] ebusy, input logic epre);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|eg));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(eid));
        check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(ebusy));
        check({tag, ".preempt"}, 32'(preempt), 32'(epre));
    endtask

    logic [3:0] prev_req;
    logic [3:0] exp_g;
    int         tenure;

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check_grant("reset", 4'b0000, 2'd0, 3'd0, 1'b0);

        // 1. Fixed priority, req=1010 held: agent 1 for 4 cycles, preempt, dead cycle, regrant
        reset   = 1'b0;
        rr_mode = 1'b0;
        req     = 4'b1010;
        tick();
        check_grant("fix.g1", 4'b0010, 2'd1, 3'd1, 1'b0);
        for (int h = 2; h <= 4; h++) begin
            tick();
            check_grant("fix.hold", 4'b0010, 2'd1, 3'(h), 1'b0);
        end
        tick();
        check_grant("fix.preempt", 4'b0000, 2'd0, 3'd0, 1'b1);
        tick();
        check_grant("fix.regrant", 4'b0010, 2'd1, 3'd1, 1'b0);

        // 2. Round-robin, req=1111 held: agents 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        rr_mode = 1'b1;
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            check_grant("rr.grant", exp_g, 2'(k % 4), 3'd1, 1'b0);
            for (int h = 2; h <= 4; h++) begin
                tick();
                check_grant("rr.hold", exp_g, 2'(k % 4), 3'(h), 1'b0);
            end
            tick();
            check_grant("rr.dead", 4'b0000, 2'd0, 3'd0, 1'b1);
        end

        // 3. Release: agent 2 drops after 2 cycles, pending agent 3 follows
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset   = 1'b0;
        rr_mode = 1'b0;
        req     = 4'b0100;
        tick();
        check_grant("rel.g2", 4'b0100, 2'd2, 3'd1, 1'b0);
        req = 4'b1100;
        tick();
        check_grant("rel.hold", 4'b0100, 2'd2, 3'd2, 1'b0);
        req = 4'b1000;
        tick();
        check_grant("rel.drop", 4'b0000, 2'd0, 3'd0, 1'b0);
        tick();
        check_grant("rel.g3", 4'b1000, 2'd3, 3'd1, 1'b0);

        // 4. Reset mid-tenure, then RR restarts at agent 0
        reset   = 1'b1;
        req     = 4'b1111;
        rr_mode = 1'b1;
        tick();
        check_grant("rst.mid", 4'b0000, 2'd0, 3'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_grant("rst.g0", 4'b0001, 2'd0, 3'd1, 1'b0);

        // 5. Unlimited tenure: continuous grant, saturating one-bit counter
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset   = 1'b0;
        req_inf = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0 || c == 39) begin
                check("inf.gnt", 32'(gnt_inf), 32'h1);
                check("inf.busy", 32'(busy_cnt_inf), 32'h1);
            end
            check("inf.preempt", 32'(preempt_inf), 32'h0);
            check("inf.valid", 32'(gnt_valid_inf), 32'h1);
        end
        req_inf = 4'b0000;

        // 6. Random requests with invariant checks
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        tenure = 0;
        req    = 4'($urandom_range(0, 15));
        for (int c = 0; c < 300; c++) begin
            prev_req = req;
            tick();
            check("rnd.onehot0", 32'($onehot0(gnt)), 32'h1);
            check("rnd.valid", 32'(gnt_valid), 32'(|gnt));
            check("rnd.req_prior", 32'(gnt & ~prev_req), 32'h0);
            tenure = gnt_valid ? tenure + 1 : 0;
            check("rnd.tenure_le_max", 32'(tenure <= 4), 32'h1);
            if (!gnt_valid) check("rnd.id_zero", 32'(gnt_id), 32'h0);
            else            check("rnd.id_match", 32'(gnt), 32'(4'b0001 << gnt_id));
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
